// File: rtl/jk_excitation_sequencer_if.sv
// Word-level request and J/K/Q bank signals of jk_excitation_sequencer.
// The slave modport is the sequencer; the master modport is its controller/bank environment.
interface jk_excitation_sequencer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q_fb;
    logic             done;
    logic             ok;
    logic             err;
    logic             clr_err;
    logic [3:0]       retry_cnt;

    modport master (
        output in_valid, in_data, q_fb, clr_err,
        input  in_ready, j, k, done, ok, err, retry_cnt
    );

    modport slave (
        input  in_valid, in_data, q_fb, clr_err,
        output in_ready, j, k, done, ok, err, retry_cnt
    );
endinterface

// File: rtl/jk_excitation_sequencer.sv
// Drives a bank of JK flip-flops toward a requested word, verifying Q and retrying on mismatch.
// Define JK_TOGGLE_MODE_EN to drive changing bits with J=K=1 instead of set/reset.
module jk_excitation_sequencer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_RETRY = 2
) (
    input logic                   clk,
    input logic                   rst,
    jk_excitation_sequencer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StApply, StCheck} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic [3:0]       retry_q, retry_d;

    function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] t);
`ifdef JK_TOGGLE_MODE_EN
        return q ^ t;
`else
        return ~q & t;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] t);
`ifdef JK_TOGGLE_MODE_EN
        return q ^ t;
`else
        return q & ~t;
`endif
    endfunction

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        j_d      = '0;
        k_d      = '0;
        done_d   = 1'b0;
        ok_d     = ok_q;
        // A set event below overrides this clear on the same edge.
        err_d    = err_q & ~bus.clr_err;
        retry_d  = retry_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    target_d = bus.in_data;
                    j_d      = excite_j(bus.q_fb, bus.in_data);
                    k_d      = excite_k(bus.q_fb, bus.in_data);
                    retry_d  = 4'd0;
                    state_d  = StApply;
                end
            end
            StApply: begin
                state_d = StCheck;
            end
            StCheck: begin
                if (bus.q_fb == target_q) begin
                    done_d  = 1'b1;
                    ok_d    = 1'b1;
                    state_d = StIdle;
                end else if (retry_q < 4'(MAX_RETRY)) begin
                    retry_d = retry_q + 4'd1;
                    j_d     = excite_j(bus.q_fb, target_q);
                    k_d     = excite_k(bus.q_fb, target_q);
                    state_d = StApply;
                end else begin
                    done_d  = 1'b1;
                    ok_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            target_q <= '0;
            j_q      <= '0;
            k_q      <= '0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            retry_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            j_q      <= j_d;
            k_q      <= k_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            retry_q  <= retry_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.j         = j_q;
    assign bus.k         = k_q;
    assign bus.done      = done_q;
    assign bus.ok        = ok_q;
    assign bus.err       = err_q;
    assign bus.retry_cnt = retry_q;
endmodule
